// File: rtl/jam_pkg.sv
`default_nettype none
//==============================================================================
// Package  : jam_pkg
// Summary  : Shared types and helpers for the jam_search assignment engine:
//            FSM state encoding, width helpers, last-permutation test.
// Revision : 1.0 - initial release
//==============================================================================
package jam_pkg;

    // Search controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_CMP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Smallest usable index width for n workers (never below one bit)
    function automatic int min_aw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Smallest accumulator width able to hold n costs of cw bits each
    function automatic int min_sw(input int n, input int cw);
        return $clog2(n * ((1 << cw) - 1) + 1);
    endfunction

    // True when the flattened permutation is fully descending, i.e. it is the
    // lexicographically last one and has no successor.
    function automatic logic is_last_perm(input logic [31:0] p, input int n, input int aw);
        logic [31:0] mask;
        logic [31:0] a;
        logic [31:0] b;
        logic        last;
        mask = (32'd1 << aw) - 32'd1;
        last = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i < n - 1) begin
                a = (p >> (i * aw)) & mask;
                b = (p >> ((i + 1) * aw)) & mask;
                if (a < b) last = 1'b0;
            end
        end
        return last;
    endfunction

endpackage
`default_nettype wire

// File: rtl/perm_next.sv
`default_nettype none
//==============================================================================
// Module   : perm_next
// Summary  : Combinational lexicographic successor of an N-element
//            permutation (pivot, swap with rightmost larger, reverse suffix).
// Revision : 1.0 - initial release
//==============================================================================
module perm_next
    import jam_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic [N*AW-1:0] i_perm,
    output logic [N*AW-1:0] o_perm_next,
    output logic            o_last
);

    logic [AW-1:0] w_a [N];
    logic [AW-1:0] w_b [N];
    logic [AW-1:0] w_c [N];
    int            w_piv;
    int            w_succ;

    // Find pivot and successor element, swap them, then reverse the suffix
    always_comb begin
        w_piv       = 0;
        w_succ      = 0;
        o_perm_next = '0;
        for (int k = 0; k < N; k++) begin
            w_a[k] = i_perm[k*AW +: AW];
        end
        // Later hits overwrite earlier ones, leaving the largest pivot index
        for (int i = 0; i < N - 1; i++) begin
            if (w_a[i] < w_a[i+1]) w_piv = i;
        end
        for (int j = 0; j < N; j++) begin
            if ((j > w_piv) && (w_a[j] > w_a[w_piv])) w_succ = j;
        end
        w_b         = w_a;
        w_b[w_piv]  = w_a[w_succ];
        w_b[w_succ] = w_a[w_piv];
        w_c         = w_b;
        for (int k = 0; k < N; k++) begin
            if (k > w_piv) w_c[k] = w_b[N + w_piv - k];
        end
        for (int k = 0; k < N; k++) begin
            o_perm_next[k*AW +: AW] = w_c[k];
        end
    end

    assign o_last = is_last_perm(32'(i_perm), N, AW);

endmodule
`default_nettype wire

// File: rtl/jam_search.sv
`default_nettype none
//==============================================================================
// Module   : jam_search
// Summary  : Exhaustive N x N job-assignment search. Walks every permutation
//            in lexicographic order, one cost lookup per cycle, and reports
//            the minimum total, how many permutations hit it, and the first
//            optimal assignment. Optional pruning of hopeless permutations.
// Revision : 1.0 - initial release
//==============================================================================
module jam_search
    import jam_pkg::*;
#(
    parameter int N     = 8,
    parameter int CW    = 7,
    parameter int AW    = 3,
    parameter int SW    = 10,
    parameter int MCW   = 16,
    parameter int PRUNE = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Start,
    input  logic [CW-1:0]   Cost,
    output logic [AW-1:0]   W,
    output logic [AW-1:0]   J,
    output logic            Busy,
    output logic            Valid,
    output logic [SW-1:0]   MinCost,
    output logic [MCW-1:0]  MatchCount,
    output logic [N*AW-1:0] BestPerm
);

    function automatic logic [N*AW-1:0] f_identity();
        logic [N*AW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*AW +: AW] = AW'(k);
        return v;
    endfunction

    localparam logic [N*AW-1:0] c_ident = f_identity();

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N*AW-1:0] r_perm;
    logic [N*AW-1:0] r_best;
    logic [AW-1:0]   r_row;
    logic [AW-1:0]   r_j;
    logic [SW-1:0]   r_acc;
    logic [SW-1:0]   r_min;
    logic [MCW-1:0]  r_cnt;
    logic            r_pruned;
    logic            r_busy;
    logic            r_valid;

    logic [N*AW-1:0] w_perm_next;
    logic            w_perm_last;
    logic [SW:0]     w_cost_ext;
    logic [SW:0]     w_sum;
    logic            w_prune_hit;
    logic            w_last_row;
    logic            w_row_end;
    logic [AW-1:0]   w_perm_arr [N];

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign w_perm_arr[k] = r_perm[k*AW +: AW];
    end

    perm_next #(
        .N  (N),
        .AW (AW)
    ) u_perm_next (
        .i_perm      (r_perm),
        .o_perm_next (w_perm_next),
        .o_last      (w_perm_last)
    );

    // One extra bit on the sum keeps the prune compare exact near all-ones
    assign w_cost_ext  = {{(SW + 1 - CW){1'b0}}, Cost};
    assign w_sum       = {1'b0, r_acc} + w_cost_ext;
    assign w_prune_hit = (PRUNE != 0) && (w_sum > {1'b0, r_min});
    assign w_last_row  = (r_row == AW'(N - 1));
    assign w_row_end   = w_last_row || w_prune_hit;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (Start) w_state_nxt = S_EVAL;
            S_EVAL:         if (w_row_end) w_state_nxt = S_CMP;
            S_CMP:          w_state_nxt = w_perm_last ? S_DONE : S_EVAL;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: lookup indices, accumulator, permutation and result registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_perm   <= c_ident;
            r_best   <= '0;
            r_row    <= '0;
            r_j      <= '0;
            r_acc    <= '0;
            r_min    <= '1;
            r_cnt    <= '0;
            r_pruned <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        r_perm   <= c_ident;
                        r_row    <= '0;
                        r_j      <= '0;
                        r_acc    <= '0;
                        r_min    <= '1;
                        r_cnt    <= '0;
                        r_pruned <= 1'b0;
                        r_busy   <= 1'b1;
                        r_valid  <= 1'b0;
                    end
                end
                S_EVAL: begin
                    r_acc <= w_sum[SW-1:0];
                    if (w_prune_hit) r_pruned <= 1'b1;
                    if (!w_row_end) begin
                        r_row <= r_row + 1'b1;
                        r_j   <= w_perm_arr[r_row + 1'b1];
                    end
                end
                S_CMP: begin
                    if (!r_pruned) begin
                        if (r_acc < r_min) begin
                            r_min  <= r_acc;
                            r_cnt  <= MCW'(1);
                            r_best <= r_perm;
                        end else if (r_acc == r_min) begin
                            // Equal cost keeps the earlier, lexicographically smaller optimum
                            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    if (w_perm_last) begin
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_perm   <= w_perm_next;
                        r_row    <= '0;
                        r_j      <= w_perm_next[AW-1:0];
                        r_acc    <= '0;
                        r_pruned <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign W          = r_row;
    assign J          = r_j;
    assign Busy       = r_busy;
    assign Valid      = r_valid;
    assign MinCost    = r_min;
    assign MatchCount = r_cnt;
    assign BestPerm   = r_best;

endmodule
`default_nettype wire

// File: tb/tb_jam_search.sv
`default_nettype none
//==============================================================================
// Module   : tb_jam_search
// Summary  : Directed self-checking bench for jam_search. Several parameter
//            sets run side by side from a shared Start/RST.
// Revision : 1.0 - initial release
//==============================================================================
module tb_jam_search;

    logic CLK   = 1'b0;
    logic RST   = 1'b1;
    logic Start = 1'b0;
    int   mode  = 0;

    always #5 CLK = ~CLK;

    // N=3 cost: mode 0 all fives, mode 1 zero on the anti-diagonal else nine
    function automatic logic [3:0] f_cost3(input logic [1:0] w, input logic [1:0] j, input int m);
        if (m == 0) return 4'd5;
        return (int'(j) == 2 - int'(w)) ? 4'd0 : 4'd9;
    endfunction

    // N=4 cost ROM: (W*J) mod 7
    function automatic logic [2:0] f_cost4(input logic [1:0] w, input logic [1:0] j);
        return 3'((int'(w) * int'(j)) % 7);
    endfunction

    // N=3, PRUNE=0
    logic [1:0] w3, j3;  logic [3:0] c3;  logic busy3, val3;
    logic [5:0] min3;    logic [7:0] cnt3; logic [5:0] best3;
    // N=3, PRUNE=1
    logic [1:0] w3p, j3p; logic [3:0] c3p; logic busy3p, val3p;
    logic [5:0] min3p;    logic [7:0] cnt3p; logic [5:0] best3p;
    // N=3, MCW=2
    logic [1:0] w3s, j3s; logic [3:0] c3s; logic busy3s, val3s;
    logic [5:0] min3s;    logic [1:0] cnt3s; logic [5:0] best3s;
    // N=4, PRUNE=0
    logic [1:0] w4, j4;  logic [2:0] c4;  logic busy4, val4;
    logic [4:0] min4;    logic [7:0] cnt4; logic [7:0] best4;
    // N=4, PRUNE=1
    logic [1:0] w4p, j4p; logic [2:0] c4p; logic busy4p, val4p;
    logic [4:0] min4p;    logic [7:0] cnt4p; logic [7:0] best4p;

    assign c3  = f_cost3(w3, j3, mode);
    assign c3p = f_cost3(w3p, j3p, mode);
    assign c3s = f_cost3(w3s, j3s, mode);
    assign c4  = f_cost4(w4, j4);
    assign c4p = f_cost4(w4p, j4p);

    jam_search #(.N(3), .CW(4), .AW(2), .SW(6), .MCW(8), .PRUNE(0)) u3 (
        .CLK(CLK), .RST(RST), .Start(Start), .Cost(c3), .W(w3), .J(j3),
        .Busy(busy3), .Valid(val3), .MinCost(min3), .MatchCount(cnt3), .BestPerm(best3));
    jam_search #(.N(3), .CW(4), .AW(2), .SW(6), .MCW(8), .PRUNE(1)) u3p (
        .CLK(CLK), .RST(RST), .Start(Start), .Cost(c3p), .W(w3p), .J(j3p),
        .Busy(busy3p), .Valid(val3p), .MinCost(min3p), .MatchCount(cnt3p), .BestPerm(best3p));
    jam_search #(.N(3), .CW(4), .AW(2), .SW(6), .MCW(2), .PRUNE(0)) u3s (
        .CLK(CLK), .RST(RST), .Start(Start), .Cost(c3s), .W(w3s), .J(j3s),
        .Busy(busy3s), .Valid(val3s), .MinCost(min3s), .MatchCount(cnt3s), .BestPerm(best3s));
    jam_search #(.N(4), .CW(3), .AW(2), .SW(5), .MCW(8), .PRUNE(0)) u4 (
        .CLK(CLK), .RST(RST), .Start(Start), .Cost(c4), .W(w4), .J(j4),
        .Busy(busy4), .Valid(val4), .MinCost(min4), .MatchCount(cnt4), .BestPerm(best4));
    jam_search #(.N(4), .CW(3), .AW(2), .SW(5), .MCW(8), .PRUNE(1)) u4p (
        .CLK(CLK), .RST(RST), .Start(Start), .Cost(c4p), .W(w4p), .J(j4p),
        .Busy(busy4p), .Valid(val4p), .MinCost(min4p), .MatchCount(cnt4p), .BestPerm(best4p));

    // Count cycles spent busy per instance (EVAL + CMP cycles)
    int lat3 = 0, lat4 = 0, lat4p = 0;
    always @(posedge CLK) begin
        if (busy3)  lat3  <= lat3 + 1;
        if (busy4)  lat4  <= lat4 + 1;
        if (busy4p) lat4p <= lat4p + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Start is driven on a falling edge and returns in the first EVAL cycle
    task automatic pulse_start();
        @(negedge CLK); Start = 1'b1;
        @(negedge CLK); Start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int n;
        n = 0;
        while (!(val3 && val3p && val3s && val4 && val4p) && (n < bound)) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_done"}, 64'(val3 && val3p && val3s && val4 && val4p), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b3, b4, b4p, guard;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_busy",  64'(busy3), 64'd0);
        chk("rst_valid", 64'(val3),  64'd0);
        chk("rst_min",   64'(min3),  64'd63);
        chk("rst_cnt",   64'(cnt3),  64'd0);
        chk("rst_best",  64'(best3), 64'd0);
        chk("rst_w",     64'(w3),    64'd0);
        chk("rst_j",     64'(j3),    64'd0);
        RST = 1'b0;

        // Run A: uniform costs, N=4 ROM
        mode = 0;
        b3 = lat3; b4 = lat4; b4p = lat4p;
        pulse_start();
        chk("A_busy_first", 64'(busy3), 64'd1);
        chk("A_valid_first", 64'(val3), 64'd0);
        wait_done(400, "A");
        chk("A_lat3",   64'(lat3 - b3), 64'd24);
        chk("A_busy3",  64'(busy3),     64'd0);
        chk("A_min3",   64'(min3),      64'd15);
        chk("A_cnt3",   64'(cnt3),      64'd6);
        chk("A_best3",  64'(best3),     64'h24);
        chk("A_min3p",  64'(min3p),     64'd15);
        chk("A_cnt3p",  64'(cnt3p),     64'd6);
        chk("A_best3p", 64'(best3p),    64'h24);
        chk("A_min3s",  64'(min3s),     64'd15);
        chk("A_cnt3s_sat", 64'(cnt3s),  64'd3);
        chk("A_lat4",   64'(lat4 - b4), 64'd120);
        chk("A_min4",   64'(min4),      64'd3);
        chk("A_cnt4",   64'(cnt4),      64'd1);
        chk("A_best4",  64'(best4),     64'hC6);
        chk("A_min4p",  64'(min4p),     64'd3);
        chk("A_cnt4p",  64'(cnt4p),     64'd1);
        chk("A_best4p", 64'(best4p),    64'hC6);
        chk("A_lat4p_shorter", 64'((lat4p - b4p) < 120), 64'd1);

        // Run B: new matrix after DONE, restart clears results, busy Start ignored
        mode = 1;
        b3 = lat3;
        pulse_start();
        chk("B_valid_drop", 64'(val3),  64'd0);
        chk("B_busy",       64'(busy3), 64'd1);
        chk("B_min_clear",  64'(min3),  64'd63);
        chk("B_cnt_clear",  64'(cnt3),  64'd0);
        repeat (3) @(negedge CLK);
        pulse_start();
        wait_done(400, "B");
        chk("B_lat3",   64'(lat3 - b3), 64'd24);
        chk("B_min3",   64'(min3),      64'd0);
        chk("B_cnt3",   64'(cnt3),      64'd1);
        chk("B_best3",  64'(best3),     64'h06);
        chk("B_min3p",  64'(min3p),     64'd0);
        chk("B_cnt3p",  64'(cnt3p),     64'd1);
        chk("B_best3p", 64'(best3p),    64'h06);
        chk("B_cnt3s",  64'(cnt3s),     64'd1);

        // Run C: asynchronous reset in the middle of a search
        b3 = lat3;
        guard = 0;
        pulse_start();
        while (((lat3 - b3) < 10) && (guard < 100)) begin
            @(negedge CLK);
            guard++;
        end
        chk("C_reached_cycle10", 64'(lat3 - b3), 64'd10);
        #1 RST = 1'b1;
        #1;
        chk("C_rst_busy",  64'(busy3), 64'd0);
        chk("C_rst_valid", 64'(val3),  64'd0);
        chk("C_rst_min",   64'(min3),  64'd63);
        chk("C_rst_cnt",   64'(cnt3),  64'd0);
        chk("C_rst_best",  64'(best3), 64'd0);
        chk("C_rst_w",     64'(w3),    64'd0);
        chk("C_rst_j",     64'(j3),    64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Run D: fresh search after the reset
        mode = 0;
        b3 = lat3;
        pulse_start();
        wait_done(400, "D");
        chk("D_lat3",  64'(lat3 - b3), 64'd24);
        chk("D_min3",  64'(min3),      64'd15);
        chk("D_cnt3",  64'(cnt3),      64'd6);
        chk("D_best3", 64'(best3),     64'h24);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
